// File: rtl/gen_shuffle_idx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gen_shuffle_idx_pkg                                             |
// | Purpose  : Shared definitions for the SDF FFT output-reordering logic.     |
// |            Holds the bit-reversal helper that the reorder buffer also      |
// |            uses, plus the default transform size.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gen_shuffle_idx_pkg;

  // Default log2 FFT size and the widest index the helper supports.
  localparam int DEFAULT_N = 4;
  localparam int MAX_W     = 16;

  // bitrev: out[i] = k[w-1-i] for i in 0..w-1; bits at and above w read as 0.
  // The width is a run-time argument so one function serves every FFT size.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] k,
                                              input int               w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = k[w-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gen_shuffle_idx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gen_shuffle_idx_if                                              |
// | Purpose  : Table bus between the shuffle-index generator and its readers.  |
// |   shuffle_idx : [N-1:0] x 2**N, entry k = bitrev(k) once filled            |
// |   done        : high once every entry is valid                             |
// |   master = generator (drives), slave = reorder buffer (reads)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface gen_shuffle_idx_if #(
  parameter int N = 4
);
  logic [N-1:0] shuffle_idx [2**N];
  logic         done;

  modport master (output shuffle_idx, output done);
  modport slave  (input  shuffle_idx, input  done);
endinterface
`default_nettype wire

// File: rtl/gen_shuffle_idx_bit_reverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bit_reverse                                                     |
// | Purpose  : Combinational W-bit bit reversal, out_o[i] = in_i[W-1-i].       |
// |   in_i  : [W-1:0] value to reverse                                         |
// |   out_o : [W-1:0] reversed value                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bit_reverse #(
  parameter int W = 4
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  // Pure wiring: no logic, no width growth.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign out_o[i] = in_i[W-1-i];
  end

endmodule
`default_nettype wire

// File: rtl/gen_shuffle_idx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gen_shuffle_idx                                                 |
// | Purpose  : Builds the radix-2 SDF FFT output-reordering table. Entry k     |
// |            holds bitrev_N(k). One entry is written per clock after reset;  |
// |            afterwards the table is held statically so readers can index    |
// |            it combinationally.                                             |
// |   clk    : rising-edge clock                                               |
// |   rst    : synchronous, active-high reset (clears table and restarts fill) |
// |   out_if : master side of the table bus (shuffle_idx[], done)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gen_shuffle_idx
  import gen_shuffle_idx_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                 clk,
  input  logic                 rst,
  gen_shuffle_idx_if.master    out_if
);

  localparam int NPTS = 2**N;

  // One extra counter bit so the count can rest at NPTS once the fill ends.
  logic [N:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [N-1:0] rev_w;
  logic         last_w;
  logic [N-1:0] tbl_q [NPTS];

  bit_reverse #(.W(N)) u_bit_reverse (
    .in_i  (cnt_q[N-1:0]),
    .out_o (rev_w)
  );

  // The last write happens while cnt = NPTS-1, so done rises on that same edge.
  assign last_w = (cnt_q == (N+1)'(NPTS-1));

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!done_q) begin
      cnt_d = cnt_q + 1'b1;
      if (last_w) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Per-entry register with its own write enable; reset clears every entry
  // so a fill interrupted by reset leaves no stale values behind.
  for (genvar k = 0; k < NPTS; k++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        tbl_q[k] <= '0;
      end else if (!done_q && (cnt_q == (N+1)'(k))) begin
        tbl_q[k] <= rev_w;
      end
    end
    assign out_if.shuffle_idx[k] = tbl_q[k];
  end

  assign out_if.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_shuffle_idx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gen_shuffle_idx                                              |
// | Purpose  : Self-checking bench for gen_shuffle_idx at N=4, N=3 and N=1,    |
// |            all three instances sharing one clock and reset.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_gen_shuffle_idx;

  logic clk;
  logic rst;

  gen_shuffle_idx_if #(.N(4)) if4 ();
  gen_shuffle_idx_if #(.N(3)) if3 ();
  gen_shuffle_idx_if #(.N(1)) if1 ();

  gen_shuffle_idx #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .out_if(if4));
  gen_shuffle_idx #(.N(3)) u_dut3 (.clk(clk), .rst(rst), .out_if(if3));
  gen_shuffle_idx #(.N(1)) u_dut1 (.clk(clk), .rst(rst), .out_if(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int idx;
    int exp;
  } vec_t;

  vec_t vecs [26];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rd(input int n, input int idx);
    case (n)
      4:       return int'(if4.shuffle_idx[idx]);
      3:       return int'(if3.shuffle_idx[idx]);
      default: return int'(if1.shuffle_idx[idx]);
    endcase
  endfunction

  function automatic int rd_done(input int n);
    case (n)
      4:       return int'(if4.done);
      3:       return int'(if3.done);
      default: return int'(if1.done);
    endcase
  endfunction

  // Expected N=4 entry from the hand table (vecs[0..15]).
  function automatic int exp4(input int idx);
    return vecs[idx].exp;
  endfunction

  task automatic check_table(input string tag);
    for (int v = 0; v < 26; v++) begin
      check($sformatf("%s N=%0d [%0d]", tag, vecs[v].n, vecs[v].idx),
            rd(vecs[v].n, vecs[v].idx), vecs[v].exp);
    end
    check($sformatf("%s done4", tag), rd_done(4), 1);
    check($sformatf("%s done3", tag), rd_done(3), 1);
    check($sformatf("%s done1", tag), rd_done(1), 1);
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 16; k++) check($sformatf("%s N=4 [%0d]", tag, k), rd(4, k), 0);
    for (int k = 0; k < 8; k++)  check($sformatf("%s N=3 [%0d]", tag, k), rd(3, k), 0);
    for (int k = 0; k < 2; k++)  check($sformatf("%s N=1 [%0d]", tag, k), rd(1, k), 0);
    check($sformatf("%s done4", tag), rd_done(4), 0);
    check($sformatf("%s done3", tag), rd_done(3), 0);
    check($sformatf("%s done1", tag), rd_done(1), 0);
  endtask

  // Runs the 16-edge fill, checking done timing and progressive writes.
  task automatic run_fill(input string tag);
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s e%0d done4", tag, e), rd_done(4), (e >= 16) ? 1 : 0);
      check($sformatf("%s e%0d done3", tag, e), rd_done(3), (e >= 8) ? 1 : 0);
      check($sformatf("%s e%0d done1", tag, e), rd_done(1), (e >= 2) ? 1 : 0);
      // Entries 0..e-1 written, the rest still zero.
      for (int k = 0; k < 16; k++) begin
        check($sformatf("%s e%0d N=4 [%0d]", tag, e, k), rd(4, k), (k < e) ? exp4(k) : 0);
      end
    end
  endtask

  task automatic check_permutation(input int n);
    int seen [16];
    int npts;
    npts = 1 << n;
    for (int v = 0; v < 16; v++) seen[v] = 0;
    for (int k = 0; k < npts; k++) seen[rd(n, k)]++;
    for (int v = 0; v < npts; v++) begin
      check($sformatf("perm N=%0d value %0d count", n, v), seen[v], 1);
    end
  endtask

  initial begin
    int n4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int n3 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < 16; k++) vecs[k]      = '{n: 4, idx: k, exp: n4[k]};
    for (int k = 0; k < 8; k++)  vecs[16 + k] = '{n: 3, idx: k, exp: n3[k]};
    vecs[24] = '{n: 1, idx: 0, exp: 0};
    vecs[25] = '{n: 1, idx: 1, exp: 1};

    // Reset for two edges; everything must read zero while rst is high.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // First fill.
    run_fill("fill");
    check_table("table");

    // Hold for 20 edges.
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_table("hold");

    // Restart, then reset again mid-fill after 5 writes.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("partial N=4 [%0d]", k), rd(4, k), (k < 5) ? exp4(k) : 0);
    end
    check("partial done4", rd_done(4), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("midreset");
    rst = 1'b0;

    run_fill("refill");
    check_table("retable");

    check_permutation(4);
    check_permutation(3);
    check_permutation(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
